// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types and constants for the branch/load-use hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          REG_ADDR_W = 5;

endpackage

// File: rtl/branch_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller; stats counters appear only
// when BRANCH_HAZARD_STATS_EN is defined.
interface branch_hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                  to_branch_ex;
    logic [XLEN-1:0]       branch_target_ex;
    logic                  memread_ex;
    logic [REG_ADDR_W-1:0] rd_ex;
    logic [REG_ADDR_W-1:0] rs1_id;
    logic [REG_ADDR_W-1:0] rs2_id;
    logic                  uses_rs1_id;
    logic                  uses_rs2_id;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  pc_src;
    logic [XLEN-1:0]       pc_target;
    logic                  busy;
`ifdef BRANCH_HAZARD_STATS_EN
    logic [31:0]           taken_cnt;
    logic [31:0]           stall_cnt;
    logic [31:0]           flush_cnt;
`endif

    modport master (
        output to_branch_ex, branch_target_ex, memread_ex, rd_ex,
               rs1_id, rs2_id, uses_rs1_id, uses_rs2_id,
        input  pc_write, ifid_write, ifid_flush, idex_flush, pc_src,
               pc_target, busy
`ifdef BRANCH_HAZARD_STATS_EN
        , input taken_cnt, stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  to_branch_ex, branch_target_ex, memread_ex, rd_ex,
               rs1_id, rs2_id, uses_rs1_id, uses_rs2_id,
        output pc_write, ifid_write, ifid_flush, idex_flush, pc_src,
               pc_target, busy
`ifdef BRANCH_HAZARD_STATS_EN
        , output taken_cnt, stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/branch_hazard_ctrl_loaduse_detect.sv
// Combinational load-use detector between EX (load) and ID (consumer);
// shared with the forwarding unit.
module loaduse_detect
    import hazard_pkg::*;
(
    input  logic                  i_memread_ex,
    input  logic [REG_ADDR_W-1:0] i_rd_ex,
    input  logic [REG_ADDR_W-1:0] i_rs1_id,
    input  logic [REG_ADDR_W-1:0] i_rs2_id,
    input  logic                  i_uses_rs1_id,
    input  logic                  i_uses_rs2_id,
    output logic                  o_loaduse
);
    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1 = i_uses_rs1_id && (i_rs1_id == i_rd_ex);
    assign w_hit_rs2 = i_uses_rs2_id && (i_rs2_id == i_rd_ex);
    // x0 is never a real producer, so a load to it cannot create a hazard.
    assign o_loaduse = i_memread_ex && (i_rd_ex != '0) && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Hazard controller: taken-branch redirect/flush sequencing and one-cycle
// load-use stalls. Optional counters under BRANCH_HAZARD_STATS_EN.
module branch_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int XLEN         = 32
)(
    input  logic                clk,
    input  logic                reset,
    branch_hazard_ctrl_if.slave bus
);
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_flush_cycles
        $error("FLUSH_CYCLES must be in 1..4");
    end

    // Resolving cycle is one flush cycle; FLUSH covers the remaining ones.
    localparam logic [1:0] FCNT_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

    state_t          r_state;
    logic [1:0]      r_fcnt;
    logic [XLEN-1:0] r_target;

    logic w_loaduse;
    logic w_take;
    logic w_stall;
    logic w_flushing;

    loaduse_detect u_loaduse (
        .i_memread_ex (bus.memread_ex),
        .i_rd_ex      (bus.rd_ex),
        .i_rs1_id     (bus.rs1_id),
        .i_rs2_id     (bus.rs2_id),
        .i_uses_rs1_id(bus.uses_rs1_id),
        .i_uses_rs2_id(bus.uses_rs2_id),
        .o_loaduse    (w_loaduse)
    );

    // Wrong-path decisions during FLUSH are dropped; STALL never re-stalls.
    assign w_flushing = (r_state == FLUSH);
    assign w_take     = !w_flushing && bus.to_branch_ex;
    assign w_stall    = (r_state == RUN) && w_loaduse && !bus.to_branch_ex;

    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
        bus.pc_src     = 1'b0;
        bus.pc_target  = '0;
        bus.busy       = 1'b0;
        if (!reset) begin
            bus.pc_write   = !w_stall;
            bus.ifid_write = !w_stall;
            bus.ifid_flush = w_take || w_flushing;
            bus.idex_flush = w_take || w_flushing || w_stall;
            bus.pc_src     = w_take;
            bus.pc_target  = w_take ? bus.branch_target_ex : r_target;
            bus.busy       = (r_state != RUN);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all registers update together.
        if (reset) begin
            r_state  <= RUN;
            r_fcnt   <= 2'd0;
            r_target <= '0;
        end else begin
            case (r_state)
                RUN, STALL: begin
                    if (bus.to_branch_ex) begin
                        r_target <= bus.branch_target_ex;
                        if (FLUSH_CYCLES > 1) begin
                            r_state <= FLUSH;
                            r_fcnt  <= FCNT_INIT;
                        end else begin
                            r_state <= RUN;
                        end
                    end else if (w_stall) begin
                        r_state <= STALL;
                    end else begin
                        r_state <= RUN;
                    end
                end
                FLUSH: begin
                    if (r_fcnt == 2'd0) r_state <= RUN;
                    else                r_fcnt  <= r_fcnt - 2'd1;
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef BRANCH_HAZARD_STATS_EN
    logic [31:0] r_taken_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_take && r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 32'd1;
            if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
            if ((w_take || w_flushing) && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign bus.taken_cnt = r_taken_cnt;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench: three controllers (FLUSH_CYCLES 1,2,3) share stimulus
// and are compared every cycle against a behavioural model.
module tb_branch_hazard_ctrl;

    typedef struct packed {
        logic        pc_write;
        logic        ifid_write;
        logic        ifid_flush;
        logic        idex_flush;
        logic        pc_src;
        logic [31:0] pc_target;
        logic        busy;
    } out_t;

    logic        clk;
    logic        reset;
    logic        to_branch;
    logic [31:0] tgt_in;
    logic        memread;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;

    out_t        act [3];
`ifdef BRANCH_HAZARD_STATS_EN
    logic [31:0] act_taken [3];
    logic [31:0] act_stall [3];
    logic [31:0] act_flush [3];
`endif

    int tests  = 0;
    int failed = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        branch_hazard_ctrl_if bus ();
        assign bus.to_branch_ex     = to_branch;
        assign bus.branch_target_ex = tgt_in;
        assign bus.memread_ex       = memread;
        assign bus.rd_ex            = rd;
        assign bus.rs1_id           = rs1;
        assign bus.rs2_id           = rs2;
        assign bus.uses_rs1_id      = u1;
        assign bus.uses_rs2_id      = u2;
        branch_hazard_ctrl #(.FLUSH_CYCLES(g + 1), .XLEN(32)) u_dut (
            .clk  (clk),
            .reset(reset),
            .bus  (bus.slave)
        );
        assign act[g] = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush,
                         bus.pc_src, bus.pc_target, bus.busy};
`ifdef BRANCH_HAZARD_STATS_EN
        assign act_taken[g] = bus.taken_cnt;
        assign act_stall[g] = bus.stall_cnt;
        assign act_flush[g] = bus.flush_cnt;
`endif
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: remaining flush cycles, "just stalled" flag, captured target.
    int          m_rem     [3] = '{0, 0, 0};
    bit          m_stalled [3] = '{0, 0, 0};
    logic [31:0] m_tgt     [3] = '{0, 0, 0};
    longint      m_taken   [3] = '{0, 0, 0};
    longint      m_stall   [3] = '{0, 0, 0};
    longint      m_flush   [3] = '{0, 0, 0};

    function automatic bit lu_now();
        return memread && rd != 5'd0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    endfunction

    function automatic out_t model_out(int k);
        out_t o;
        if (reset)
            o = '{pc_write:0, ifid_write:0, ifid_flush:1, idex_flush:1, pc_src:0, pc_target:0, busy:0};
        else if (m_rem[k] > 0)
            o = '{pc_write:1, ifid_write:1, ifid_flush:1, idex_flush:1, pc_src:0, pc_target:m_tgt[k], busy:1};
        else if (to_branch)
            o = '{pc_write:1, ifid_write:1, ifid_flush:1, idex_flush:1, pc_src:1, pc_target:tgt_in, busy:m_stalled[k]};
        else if (lu_now() && !m_stalled[k])
            o = '{pc_write:0, ifid_write:0, ifid_flush:0, idex_flush:1, pc_src:0, pc_target:m_tgt[k], busy:0};
        else
            o = '{pc_write:1, ifid_write:1, ifid_flush:0, idex_flush:0, pc_src:0, pc_target:m_tgt[k], busy:m_stalled[k]};
        return o;
    endfunction

    function automatic longint sat_inc(longint v);
        return (v >= 64'hFFFF_FFFF) ? v : v + 1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_rem[k] = 0; m_stalled[k] = 0; m_tgt[k] = '0;
                m_taken[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            end else if (m_rem[k] > 0) begin
                m_rem[k]--; m_stalled[k] = 0;
                m_flush[k] = sat_inc(m_flush[k]);
            end else if (to_branch) begin
                m_rem[k] = k; m_stalled[k] = 0; m_tgt[k] = tgt_in;
                m_taken[k] = sat_inc(m_taken[k]);
                m_flush[k] = sat_inc(m_flush[k]);
            end else if (lu_now() && !m_stalled[k]) begin
                m_stalled[k] = 1;
                m_stall[k] = sat_inc(m_stall[k]);
            end else begin
                m_stalled[k] = 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("model_fc%0d", k + 1), 64'(act[k]), 64'(model_out(k)));
`ifdef BRANCH_HAZARD_STATS_EN
            check($sformatf("taken_fc%0d", k + 1), 64'(act_taken[k]), 64'(m_taken[k]));
            check($sformatf("stall_fc%0d", k + 1), 64'(act_stall[k]), 64'(m_stall[k]));
            check($sformatf("flush_fc%0d", k + 1), 64'(act_flush[k]), 64'(m_flush[k]));
`endif
        end
    end

    // One cycle: change inputs just after the rising edge, return at the falling edge.
    task automatic cyc(input logic r, input logic br, input logic [31:0] t, input logic mr,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic a1, input logic a2);
        @(posedge clk);
        #1;
        reset = r; to_branch = br; tgt_in = t; memread = mr;
        rd = d; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        reset = 1; to_branch = 0; tgt_in = '0; memread = 0;
        rd = '0; rs1 = '0; rs2 = '0; u1 = 0; u2 = 0;

        repeat (3) cyc(1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("rst_ifid_flush", 64'(act[0].ifid_flush), 64'd1);
        check("rst_pc_write", 64'(act[0].pc_write), 64'd0);

        idle();
        check("run_enables", 64'({act[0].pc_write, act[0].ifid_write}), 64'h3);
        check("run_no_flush", 64'({act[0].ifid_flush, act[0].idex_flush, act[0].busy}), 64'h0);

        // Load-use on rs1, held for two cycles: only the first one stalls.
        cyc(0, 0, 32'h0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        check("lu_stall", 64'({act[0].pc_write, act[0].ifid_write, act[0].idex_flush}), 64'h1);
        cyc(0, 0, 32'h0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        check("lu_no_restall", 64'({act[0].pc_write, act[0].idex_flush}), 64'h2);
        idle();
        check("lu_back_to_run", 64'(act[0].busy), 64'd0);
        cyc(0, 0, 32'h0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
        check("lu_rd_x0", 64'(act[0].pc_write), 64'd1);
        cyc(0, 0, 32'h0, 1, 5'd7, 5'd7, 5'd9, 0, 1);
        check("lu_rs1_unused", 64'(act[0].pc_write), 64'd1);
        cyc(0, 0, 32'h0, 1, 5'd9, 5'd7, 5'd9, 0, 1);
        check("lu_rs2_stall", 64'(act[0].pc_write), 64'd0);
        // Taken branch during STALL is honoured.
        cyc(0, 1, 32'h0000_0040, 1, 5'd9, 5'd7, 5'd9, 0, 1);
        check("stall_branch", 64'({act[0].pc_src, act[0].pc_target}), {31'd0, 1'b1, 32'h40});
        repeat (3) idle();

        // Branch at T, ignored pulse at T+1 in FLUSH for FLUSH_CYCLES=3.
        cyc(0, 1, 32'h0000_0100, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("br_fc1_same_cycle", 64'({act[0].pc_src, act[0].ifid_flush, act[0].idex_flush, act[0].pc_target}),
              {29'd0, 3'b111, 32'h100});
        check("br_fc3_t", 64'({act[2].ifid_flush, act[2].busy}), 64'h2);
        cyc(0, 1, 32'h0000_0200, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("br_fc3_t1_ignored", 64'({act[2].pc_src, act[2].ifid_flush, act[2].busy, act[2].pc_target}),
              {29'd0, 3'b011, 32'h100});
        idle();
        check("br_fc1_flush_done", 64'({act[0].ifid_flush, act[0].idex_flush, act[0].pc_target}), {30'd0, 2'b00, 32'h200});
        check("br_fc3_t2", 64'({act[2].ifid_flush, act[2].idex_flush, act[2].busy}), 64'h7);
        idle();
        check("br_fc3_t3_run", 64'({act[2].ifid_flush, act[2].busy}), 64'h0);
        repeat (2) idle();

        // Branch beats a simultaneous load-use.
        cyc(0, 1, 32'h0000_0300, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        check("br_over_lu", 64'({act[0].pc_write, act[0].pc_src}), 64'h3);
        idle();
        check("br_over_lu_no_stall", 64'({act[0].busy, act[0].pc_write}), 64'h1);
        repeat (3) idle();

        // Counter scenario (FLUSH_CYCLES=2): 2 branches + 1 stall.
        cyc(1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cyc(0, 1, 32'h0000_1000, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        idle();
        cyc(0, 0, 32'h0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
        idle();
        idle();
        cyc(0, 1, 32'h0000_2000, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        idle();
`ifdef BRANCH_HAZARD_STATS_EN
        check("stats_taken", 64'(act_taken[1]), 64'd2);
        check("stats_flush", 64'(act_flush[1]), 64'd4);
        check("stats_stall", 64'(act_stall[1]), 64'd1);
`endif
        // Reset in the middle of a FLUSH sequence.
        cyc(0, 1, 32'h0000_3000, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cyc(1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle();
        check("rst_mid_flush_run", 64'({act[2].busy, act[2].ifid_flush, act[2].pc_write, act[2].pc_target}),
              {29'd0, 3'b001, 32'h0});
`ifdef BRANCH_HAZARD_STATS_EN
        check("rst_mid_flush_cnt", 64'(act_taken[1] | act_flush[1] | act_stall[1]), 64'd0);
`endif
        repeat (2) idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
